// File: rtl/xnor_maj_accum_pkg.sv
// Shared widths and helpers for the XNOR-majority accumulator and its feeders.
// Feeder and consumer blocks size their buses from the same functions so that
// accumulator, beat-counter and popcount widths always agree.
package xnor_maj_accum_pkg;

    localparam int unsigned M_DEF         = 9;
    localparam int unsigned N_DEF         = 4;
    localparam int unsigned MAX_BEATS_DEF = 16;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((r < 32) && ((32'd1 << r) < v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Bits needed for a popcount of an m-bit vector (0..m).
    function automatic int unsigned pop_width(input int unsigned m);
        return clog2(m + 1);
    endfunction

    // Bits needed for an accumulator summing up to max_beats popcounts.
    function automatic int unsigned acc_width(input int unsigned m, input int unsigned max_beats);
        return clog2(max_beats * m + 1);
    endfunction

    // Bits needed for a beat counter running 0..max_beats.
    function automatic int unsigned bc_width(input int unsigned max_beats);
        return clog2(max_beats + 1);
    endfunction

    localparam int unsigned ACC_W_DEF = acc_width(M_DEF, MAX_BEATS_DEF);
    localparam int unsigned BC_W_DEF  = bc_width(MAX_BEATS_DEF);

endpackage

// File: rtl/xnor_maj_accum_if.sv
// Beat-stream interface between the activation/weight feeders and the
// accumulator. master = feeder side, slave = accumulator side.
//   in_valid, in_last : beat qualifier and end-of-group marker
//   a                 : M-bit activation beat shared by all channels
//   w                 : N*M weights, channel c at w[c*M +: M]
//   out_valid         : one-cycle pulse per completed group
//   m                 : per-channel majority result
//   out_ovf           : group exceeded the beat limit
interface xnor_maj_accum_if #(
    parameter int unsigned M = 9,
    parameter int unsigned N = 4
);
    logic             in_valid;
    logic             in_last;
    logic [M-1:0]     a;
    logic [N*M-1:0]   w;
    logic             out_valid;
    logic [N-1:0]     m;
    logic             out_ovf;

    modport master (
        output in_valid, in_last, a, w,
        input  out_valid, m, out_ovf
    );

    modport slave (
        input  in_valid, in_last, a, w,
        output out_valid, m, out_ovf
    );
endinterface

// File: rtl/xnor_maj_accum_xnor_popcount.sv
// Combinational XNOR match count of two M-bit vectors.
//   a, w  : operands
//   cnt_c : number of bit positions where a and w agree (0..M)
module xnor_popcount
    import xnor_maj_accum_pkg::*;
#(
    parameter int unsigned M = 9
) (
    input  logic [M-1:0]              a,
    input  logic [M-1:0]              w,
    output logic [pop_width(M)-1:0]   cnt_c
);
    localparam int unsigned PW = pop_width(M);

    logic [M-1:0] match;

    assign match = ~(a ^ w);

    // Sum of match bits; synthesis folds the chain into an adder tree.
    always_comb begin
        cnt_c = '0;
        for (int unsigned i = 0; i < M; i++) begin
            cnt_c = cnt_c + PW'(match[i]);
        end
    end
endmodule

// File: rtl/xnor_maj_accum.sv
// Multi-channel XNOR-majority accumulator.
// Pipeline: S1 input register, S2 per-channel popcount register, S3 group
// accumulators, then a registered threshold compare (3-cycle latency from
// the edge sampling in_last to the out_valid cycle).
//   clk, rst : clock and synchronous active-high reset
//   bus      : beat stream in, one majority bit per channel out per group
module xnor_maj_accum
    import xnor_maj_accum_pkg::*;
#(
    parameter int unsigned M         = M_DEF,
    parameter int unsigned N         = N_DEF,
    parameter int unsigned MAX_BEATS = MAX_BEATS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    xnor_maj_accum_if.slave  bus
);
    localparam int unsigned PW    = pop_width(M);
    localparam int unsigned ACC_W = acc_width(M, MAX_BEATS);
    localparam int unsigned BC_W  = bc_width(MAX_BEATS);
    localparam int unsigned CW    = ACC_W + 1;

    // S1 input register
    logic           s1_valid;
    logic           s1_last;
    logic [M-1:0]   s1_a;
    logic [N*M-1:0] s1_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_a     <= '0;
            s1_w     <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            s1_last  <= bus.in_valid & bus.in_last;
            s1_a     <= bus.a;
            s1_w     <= bus.w;
        end
    end

    // S2 per-channel popcount
    logic [PW-1:0] pop_c  [N];
    logic [PW-1:0] s2_pop [N];
    logic          s2_valid;
    logic          s2_last;

    for (genvar c = 0; c < N; c++) begin : g_pop
        xnor_popcount #(.M(M)) u_pop (
            .a     (s1_a),
            .w     (s1_w[c*M +: M]),
            .cnt_c (pop_c[c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            for (int unsigned c = 0; c < N; c++) s2_pop[c] <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            for (int unsigned c = 0; c < N; c++) s2_pop[c] <= pop_c[c];
        end
    end

    // S3 group accumulation; grp_open is low at reset and after a last beat,
    // so the next valid beat restarts the group.
    logic [ACC_W-1:0] acc [N];
    logic [BC_W-1:0]  bc;
    logic             ovf;
    logic             grp_open;
    logic             s3_close;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < N; c++) acc[c] <= '0;
            bc       <= '0;
            ovf      <= 1'b0;
            grp_open <= 1'b0;
            s3_close <= 1'b0;
        end else begin
            s3_close <= s2_valid & s2_last;
            if (s2_valid) begin
                if (!grp_open) begin
                    for (int unsigned c = 0; c < N; c++) acc[c] <= ACC_W'(s2_pop[c]);
                    bc  <= BC_W'(1);
                    ovf <= 1'b0;
                end else if (bc < BC_W'(MAX_BEATS)) begin
                    for (int unsigned c = 0; c < N; c++) acc[c] <= acc[c] + ACC_W'(s2_pop[c]);
                    bc <= bc + BC_W'(1);
                end else begin
                    ovf <= 1'b1;
                end
                grp_open <= ~s2_last;
            end
        end
    end

    // Majority threshold 2*acc >= bc*M, ties to 1, evaluated in ACC_W+1 bits.
    logic [N-1:0]  maj_c;
    logic [CW-1:0] thr_c;

    always_comb begin
        thr_c = CW'(bc) * CW'(M);
        maj_c = '0;
        for (int unsigned c = 0; c < N; c++) begin
            maj_c[c] = ({1'b0, acc[c]} << 1) >= thr_c;
        end
    end

    // Output register; m and out_ovf hold between pulses.
    logic         out_valid_q;
    logic [N-1:0] m_q;
    logic         out_ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            m_q         <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            out_valid_q <= s3_close;
            if (s3_close) begin
                m_q       <= maj_c;
                out_ovf_q <= ovf;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.m         = m_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_xnor_maj_accum.sv
module tb_xnor_maj_accum;
    localparam int unsigned M  = 9;
    localparam int unsigned N  = 2;
    localparam int unsigned MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    xnor_maj_accum_if #(.M(M), .N(N)) bus ();

    xnor_maj_accum #(.M(M), .N(N), .MAX_BEATS(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected output pulses, in the cycle they must appear
    typedef struct {
        int         when;
        logic [1:0] m;
        logic       ovf;
    } exp_t;
    exp_t       exp_q[$];
    logic [1:0] hold_m   = 2'b00;
    logic       hold_ovf = 1'b0;
    bit         mon_en   = 1'b0;

    // Every cycle: either the scheduled pulse, or no pulse with held outputs.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].when == cyc) begin
                chk("out_valid_pulse", 32'(bus.out_valid), 32'd1);
                chk("m", 32'(bus.m), 32'(exp_q[0].m));
                chk("out_ovf", 32'(bus.out_ovf), 32'(exp_q[0].ovf));
                hold_m   = exp_q[0].m;
                hold_ovf = exp_q[0].ovf;
                exp_q.pop_front();
            end else begin
                chk("out_valid_idle", 32'(bus.out_valid), 32'd0);
                chk("m_hold", 32'(bus.m), 32'(hold_m));
                chk("out_ovf_hold", 32'(bus.out_ovf), 32'(hold_ovf));
            end
        end
    end

    // Reference model: the pops of the open group kept as a list of beats
    int unsigned grp_p0[$];
    int unsigned grp_p1[$];

    function automatic int unsigned xpop(input logic [8:0] x, input logic [8:0] y);
        logic [8:0] t;
        t = ~(x ^ y);
        return $countones(t);
    endfunction

    task automatic model_close(output logic [1:0] mm, output logic ov);
        int unsigned k, s0, s1;
        k  = (grp_p0.size() < MB) ? grp_p0.size() : MB;
        s0 = 0;
        s1 = 0;
        for (int unsigned i = 0; i < k; i++) begin
            s0 += grp_p0[i];
            s1 += grp_p1[i];
        end
        mm[0] = (2 * s0 >= k * M);
        mm[1] = (2 * s1 >= k * M);
        ov    = (grp_p0.size() > MB);
    endtask

    // Drive one cycle; use_exp selects the table's expectation over the model's.
    task automatic step(input bit v, input bit l, input bit r,
                        input logic [8:0] av, input logic [17:0] wv,
                        input bit use_exp, input logic [1:0] em, input bit eo);
        int         e;
        logic [1:0] mm;
        logic       ov;
        exp_t       x;
        bus.in_valid = v;
        bus.in_last  = l;
        bus.a        = av;
        bus.w        = wv;
        rst          = r;
        @(posedge clk);
        e = cyc + 1;
        if (r) begin
            for (int i = exp_q.size() - 1; i >= 0; i--)
                if (exp_q[i].when >= e) exp_q.delete(i);
            hold_m   = 2'b00;
            hold_ovf = 1'b0;
            grp_p0.delete();
            grp_p1.delete();
        end else if (v) begin
            grp_p0.push_back(xpop(av, wv[8:0]));
            grp_p1.push_back(xpop(av, wv[17:9]));
            if (l) begin
                model_close(mm, ov);
                x.when = e + 3;
                x.m    = use_exp ? em : mm;
                x.ovf  = use_exp ? eo : ov;
                exp_q.push_back(x);
                grp_p0.delete();
                grp_p1.delete();
            end
        end
        #1;
    endtask

    typedef struct {
        bit         v;
        bit         l;
        bit         r;
        logic [8:0] a;
        logic [17:0] w;
        logic [1:0] em;
        bit         eo;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input bit v, input bit l, input bit r, input logic [8:0] av,
                                input logic [17:0] wv, input logic [1:0] em, input bit eo);
        vec_t t;
        t.v = v; t.l = l; t.r = r; t.a = av; t.w = wv; t.em = em; t.eo = eo;
        tbl.push_back(t);
    endfunction

    function automatic void bubbles(input int n);
        for (int i = 0; i < n; i++) add(0, 0, 0, 9'h000, 18'h0, 2'b00, 0);
    endfunction

    initial begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.a        = '0;
        bus.w        = '0;

        step(0, 0, 1, 9'h0, 18'h0, 0, 2'b00, 0);
        mon_en = 1'b1;
        step(0, 0, 1, 9'h0, 18'h0, 0, 2'b00, 0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_m", 32'(bus.m), 32'd0);
        chk("reset_out_ovf", 32'(bus.out_ovf), 32'd0);

        // single-beat group: ch0 9/9, ch1 0/9
        add(1, 1, 0, 9'h1FF, {9'h000, 9'h1FF}, 2'b01, 0);
        bubbles(5);
        // two beats: ch0 5+4 = 9 (tie), ch1 4+4 = 8
        add(1, 0, 0, 9'h000, {9'h01F, 9'h00F}, 2'b00, 0);
        add(1, 1, 0, 9'h000, {9'h01F, 9'h01F}, 2'b01, 0);
        bubbles(5);
        // back-to-back singles, alternating full match / full mismatch
        add(1, 1, 0, 9'h0A5, {9'h0A5, 9'h0A5}, 2'b11, 0);
        add(1, 1, 0, 9'h0A5, {9'h15A, 9'h15A}, 2'b00, 0);
        add(1, 1, 0, 9'h0A5, {9'h0A5, 9'h0A5}, 2'b11, 0);
        add(1, 1, 0, 9'h0A5, {9'h15A, 9'h15A}, 2'b00, 0);
        bubbles(5);
        // aborted group, then a last beat in the reset cycle that must be dropped
        add(1, 0, 0, 9'h1FF, {9'h1FF, 9'h1FF}, 2'b00, 0);
        add(1, 0, 0, 9'h1FF, {9'h1FF, 9'h1FF}, 2'b00, 0);
        add(1, 1, 1, 9'h1FF, {9'h1FF, 9'h1FF}, 2'b00, 0);
        add(1, 1, 0, 9'h1FF, {9'h000, 9'h000}, 2'b00, 0);
        bubbles(5);
        // five beats with limit four: fifth beat ignored, ovf set
        for (int i = 0; i < 4; i++) add(1, 0, 0, 9'h1FF, {9'h000, 9'h1FF}, 2'b00, 0);
        add(1, 1, 0, 9'h1FF, {9'h1FF, 9'h000}, 2'b01, 1);
        add(1, 1, 0, 9'h1FF, {9'h000, 9'h1FF}, 2'b01, 0);
        bubbles(5);
        // three beats unbubbled, then bubbled: ch0 5+4+0 = 9/27, ch1 5+4+9 = 18/27
        add(1, 0, 0, 9'h000, {9'h00F, 9'h00F}, 2'b00, 0);
        add(1, 0, 0, 9'h000, {9'h01F, 9'h01F}, 2'b00, 0);
        add(1, 1, 0, 9'h000, {9'h000, 9'h1FF}, 2'b10, 0);
        bubbles(5);
        add(1, 0, 0, 9'h000, {9'h00F, 9'h00F}, 2'b00, 0);
        bubbles(2);
        add(1, 0, 0, 9'h000, {9'h01F, 9'h01F}, 2'b00, 0);
        bubbles(2);
        add(1, 1, 0, 9'h000, {9'h000, 9'h1FF}, 2'b10, 0);
        bubbles(6);

        foreach (tbl[i])
            step(tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].a, tbl[i].w, 1'b1, tbl[i].em, tbl[i].eo);

        // Randomised traffic against the model, with occasional resets
        for (int i = 0; i < 1500; i++) begin
            bit r, v, l;
            r = ($urandom_range(99) < 2);
            v = ($urandom_range(99) < 70);
            l = ($urandom_range(99) < (((i / 150) % 2 == 0) ? 30 : 8));
            step(v, l, r, 9'($urandom), 18'($urandom), 1'b0, 2'b00, 1'b0);
        end

        for (int i = 0; i < 6; i++) step(0, 0, 0, 9'h0, 18'h0, 0, 2'b00, 0);
        chk("pending_pulses", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
